// File: rtl/datapath_ctrl_pkg.sv
// Shared definitions for the datapath sequencer: FSM states, F codes and
// the fixed micro-sequence ROM contents.
package datapath_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_SW = 2'd1,
    ISSUE   = 2'd2,
    DONE    = 2'd3
  } state_e;

  localparam logic [3:0] F_NOP      = 4'b0000;
  localparam logic [3:0] F_LDX_SW   = 4'b0001;
  localparam logic [3:0] F_LDY_IMM3 = 4'b0010;
  localparam logic [3:0] F_ALU_Z0   = 4'b0011;
  localparam logic [3:0] F_MOVY_Z   = 4'b0100;
  localparam logic [3:0] F_ALU_Z1   = 4'b0101;
  localparam logic [3:0] F_MOVX_Z   = 4'b0110;

  // Number of steps in the sequence selected by op.
  function automatic logic [2:0] seq_len(input logic [1:0] op);
    logic [2:0] len;
    case (op)
      2'b00:   len = 3'd1;
      2'b01:   len = 3'd3;
      2'b10:   len = 3'd4;
      default: len = 3'd6;
    endcase
    return len;
  endfunction

  // F code issued at a given step of a given sequence; NOP past the end.
  function automatic logic [3:0] seq_code(input logic [1:0] op, input logic [2:0] step);
    logic [3:0] code;
    code = F_NOP;
    case (op)
      2'b00: begin
        if (step == 3'd0) code = F_LDX_SW;
      end
      2'b01: begin
        case (step)
          3'd0:    code = F_LDX_SW;
          3'd1:    code = F_LDY_IMM3;
          3'd2:    code = F_ALU_Z0;
          default: code = F_NOP;
        endcase
      end
      2'b10: begin
        case (step)
          3'd0:    code = F_LDY_IMM3;
          3'd1:    code = F_ALU_Z0;
          3'd2:    code = F_MOVY_Z;
          3'd3:    code = F_ALU_Z1;
          default: code = F_NOP;
        endcase
      end
      default: begin
        case (step)
          3'd0:    code = F_LDX_SW;
          3'd1:    code = F_LDY_IMM3;
          3'd2:    code = F_ALU_Z0;
          3'd3:    code = F_MOVY_Z;
          3'd4:    code = F_ALU_Z1;
          3'd5:    code = F_MOVX_Z;
          default: code = F_NOP;
        endcase
      end
    endcase
    return code;
  endfunction

endpackage

// File: rtl/datapath_sequencer_seq_rom.sv
// Combinational sequence lookup: current code, following code and the
// sequence length for the latched op and current step.
module seq_rom
  import datapath_ctrl_pkg::*;
(
  input  logic [1:0] op_i,
  input  logic [2:0] step_i,
  output logic [3:0] curCode_o,
  output logic [3:0] nxtCode_o,
  output logic [2:0] len_o
);

  logic [2:0] stepNext;

  // Look up this step and the one after it so the FSM can decide ahead.
  always_comb begin
    stepNext  = step_i + 3'd1;
    curCode_o = seq_code(op_i, step_i);
    nxtCode_o = seq_code(op_i, stepNext);
    len_o     = seq_len(op_i);
  end

endmodule

// File: rtl/datapath_sequencer.sv
// Micro-sequencer that walks fixed F-code sequences into the datapath
// control decoder, holding each code for STEP_CYCLES cycles and stalling
// switch-load steps until the operator strobes sw_valid.
module datapath_sequencer
  import datapath_ctrl_pkg::*;
#(
  parameter int STEP_CYCLES = 1,
  parameter bit WAIT_SW_EN  = 1'b1
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       start,
  input  logic [1:0] op,
  input  logic       sw_valid,
  input  logic       abort,
  output logic [3:0] F,
  output logic       busy,
  output logic       done,
  output logic [2:0] step
);

  if (STEP_CYCLES < 1 || STEP_CYCLES > 15) begin : gBadStepCycles
    $error("datapath_sequencer: STEP_CYCLES must be in 1..15");
  end

  localparam logic [3:0] HOLD_LAST = 4'(STEP_CYCLES - 1);

  state_e     state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [2:0] step_q, step_d;
  logic [3:0] holdCnt_q, holdCnt_d;
  logic [3:0] f_q, f_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic [3:0] curCode, nxtCode;
  logic [2:0] seqLen, lastStep;

  seq_rom uRom (
    .op_i      (op_q),
    .step_i    (step_q),
    .curCode_o (curCode),
    .nxtCode_o (nxtCode),
    .len_o     (seqLen)
  );

  // Next state, counters and the registered output values for the next cycle.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    step_d    = step_q;
    holdCnt_d = holdCnt_q;
    f_d       = F_NOP;
    lastStep  = seqLen - 3'd1;

    case (state_q)
      IDLE: begin
        step_d = 3'd0;
        if (start) begin
          op_d      = op;
          holdCnt_d = 4'd0;
          if (WAIT_SW_EN && seq_code(op, 3'd0) == F_LDX_SW) begin
            state_d = WAIT_SW;
          end else begin
            state_d = ISSUE;
            f_d     = seq_code(op, 3'd0);
          end
        end
      end
      WAIT_SW: begin
        if (sw_valid) begin
          state_d   = ISSUE;
          holdCnt_d = 4'd0;
          f_d       = curCode;
        end
      end
      ISSUE: begin
        if (holdCnt_q == HOLD_LAST) begin
          holdCnt_d = 4'd0;
          if (step_q == lastStep) begin
            state_d = DONE;
          end else begin
            step_d = step_q + 3'd1;
            if (WAIT_SW_EN && nxtCode == F_LDX_SW) begin
              state_d = WAIT_SW;
            end else begin
              f_d = nxtCode;
            end
          end
        end else begin
          holdCnt_d = holdCnt_q + 4'd1;
          f_d       = curCode;
        end
      end
      DONE: begin
        state_d   = IDLE;
        step_d    = 3'd0;
        holdCnt_d = 4'd0;
      end
      default: begin
        state_d   = IDLE;
        step_d    = 3'd0;
        holdCnt_d = 4'd0;
      end
    endcase

    if (abort && state_q != IDLE) begin
      state_d   = IDLE;
      step_d    = 3'd0;
      holdCnt_d = 4'd0;
      f_d       = F_NOP;
    end

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State, counters and outputs all update together on the clock edge.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q   <= IDLE;
      op_q      <= 2'b00;
      step_q    <= 3'd0;
      holdCnt_q <= 4'd0;
      f_q       <= F_NOP;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      step_q    <= step_d;
      holdCnt_q <= holdCnt_d;
      f_q       <= f_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign F    = f_q;
  assign busy = busy_q;
  assign done = done_q;
  assign step = step_q;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Self-checking bench for datapath_sequencer using three parameterisations:
// A (STEP_CYCLES=1, no switch wait), B (1, wait), C (3, wait).
module tb_datapath_sequencer;

  logic       Clock;
  logic       Resetn;
  logic       start;
  logic [1:0] op;
  logic       sw_valid;
  logic       abort;

  logic [3:0] fA, fB, fC;
  logic       busyA, busyB, busyC;
  logic       doneA, doneB, doneC;
  logic [2:0] stepA, stepB, stepC;

  int checks;
  int failures;

  typedef struct {
    logic       start;
    logic [1:0] op;
    logic       sw;
    logic       abort;
    logic [3:0] f;
    logic       busy;
    logic       done;
    logic [2:0] step;
  } vec_t;

  vec_t vecs[18];

  datapath_sequencer #(.STEP_CYCLES(1), .WAIT_SW_EN(1'b0)) dutA (
    .Clock(Clock), .Resetn(Resetn), .start(start), .op(op), .sw_valid(sw_valid),
    .abort(abort), .F(fA), .busy(busyA), .done(doneA), .step(stepA)
  );

  datapath_sequencer #(.STEP_CYCLES(1), .WAIT_SW_EN(1'b1)) dutB (
    .Clock(Clock), .Resetn(Resetn), .start(start), .op(op), .sw_valid(sw_valid),
    .abort(abort), .F(fB), .busy(busyB), .done(doneB), .step(stepB)
  );

  datapath_sequencer #(.STEP_CYCLES(3), .WAIT_SW_EN(1'b1)) dutC (
    .Clock(Clock), .Resetn(Resetn), .start(start), .op(op), .sw_valid(sw_valid),
    .abort(abort), .F(fC), .busy(busyC), .done(doneC), .step(stepC)
  );

  // Free-running clock, period 10.
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion earlier");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(input logic s, input logic [1:0] o, input logic sw, input logic ab,
                              input logic [3:0] f, input logic b, input logic d, input logic [2:0] st);
    vec_t v;
    v.start = s; v.op = o; v.sw = sw; v.abort = ab;
    v.f = f; v.busy = b; v.done = d; v.step = st;
    return v;
  endfunction

  task automatic applyStimulus(input logic s, input logic [1:0] o, input logic sw, input logic ab);
    start    = s;
    op       = o;
    sw_valid = sw;
    abort    = ab;
  endtask

  task automatic stepCycle();
    @(posedge Clock);
    #1;
  endtask

  task automatic checkOutput(input string name,
                             input logic [3:0] af, input logic ab, input logic ad, input logic [2:0] as,
                             input logic [3:0] ef, input logic eb, input logic ed, input logic [2:0] es);
    checks++;
    if (af !== ef || ab !== eb || ad !== ed || as !== es) begin
      failures++;
      $display("[TB] FAIL %s: got F=%b busy=%b done=%b step=%0d, expected F=%b busy=%b done=%b step=%0d",
               name, af, ab, ad, as, ef, eb, ed, es);
    end
  endtask

  task automatic checkDut(input int which, input string name,
                          input logic [3:0] ef, input logic eb, input logic ed, input logic [2:0] es);
    case (which)
      0:       checkOutput(name, fA, busyA, doneA, stepA, ef, eb, ed, es);
      1:       checkOutput(name, fB, busyB, doneB, stepB, ef, eb, ed, es);
      default: checkOutput(name, fC, busyC, doneC, stepC, ef, eb, ed, es);
    endcase
  endtask

  task automatic checkInt(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic resetAll();
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
    Resetn = 1'b0;
    stepCycle();
    Resetn = 1'b1;
  endtask

  initial begin
    int cyc;
    int doneCount;

    checks   = 0;
    failures = 0;
    Resetn   = 1'b0;
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);

    // Table for dutA: op00 minimum run, op01 with ignored start/sw,
    // op11 aborted at step 2, then op10 accepted right after the abort.
    vecs[0]  = mk(1, 2'b00, 0, 0, 4'b0001, 1, 0, 3'd0);
    vecs[1]  = mk(0, 2'b00, 0, 0, 4'b0000, 1, 1, 3'd0);
    vecs[2]  = mk(0, 2'b00, 0, 0, 4'b0000, 0, 0, 3'd0);
    vecs[3]  = mk(1, 2'b01, 0, 0, 4'b0001, 1, 0, 3'd0);
    vecs[4]  = mk(1, 2'b11, 0, 0, 4'b0010, 1, 0, 3'd1);
    vecs[5]  = mk(0, 2'b11, 1, 0, 4'b0011, 1, 0, 3'd2);
    vecs[6]  = mk(0, 2'b00, 0, 0, 4'b0000, 1, 1, 3'd2);
    vecs[7]  = mk(0, 2'b00, 0, 0, 4'b0000, 0, 0, 3'd0);
    vecs[8]  = mk(1, 2'b11, 0, 1, 4'b0001, 1, 0, 3'd0);
    vecs[9]  = mk(0, 2'b00, 0, 0, 4'b0010, 1, 0, 3'd1);
    vecs[10] = mk(0, 2'b00, 0, 0, 4'b0011, 1, 0, 3'd2);
    vecs[11] = mk(0, 2'b00, 1, 1, 4'b0000, 0, 0, 3'd0);
    vecs[12] = mk(1, 2'b10, 0, 0, 4'b0010, 1, 0, 3'd0);
    vecs[13] = mk(0, 2'b00, 0, 0, 4'b0011, 1, 0, 3'd1);
    vecs[14] = mk(0, 2'b00, 0, 0, 4'b0100, 1, 0, 3'd2);
    vecs[15] = mk(0, 2'b00, 0, 0, 4'b0101, 1, 0, 3'd3);
    vecs[16] = mk(0, 2'b00, 0, 0, 4'b0000, 1, 1, 3'd3);
    vecs[17] = mk(0, 2'b00, 0, 0, 4'b0000, 0, 0, 3'd0);

    #2;
    checkDut(0, "reset_A", 4'b0000, 0, 0, 3'd0);
    checkDut(1, "reset_B", 4'b0000, 0, 0, 3'd0);
    checkDut(2, "reset_C", 4'b0000, 0, 0, 3'd0);

    resetAll();
    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].start, vecs[i].op, vecs[i].sw, vecs[i].abort);
      stepCycle();
      checkDut(0, $sformatf("table_A[%0d]", i), vecs[i].f, vecs[i].busy, vecs[i].done, vecs[i].step);
    end

    // op01 on dutB with the switch strobe arriving after five waiting cycles.
    resetAll();
    applyStimulus(1'b1, 2'b01, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      stepCycle();
      checkDut(1, $sformatf("wait_B[%0d]", i), 4'b0000, 1, 0, 3'd0);
      applyStimulus(1'b0, 2'b01, 1'b0, 1'b0);
    end
    applyStimulus(1'b0, 2'b00, 1'b1, 1'b0);
    stepCycle();
    checkDut(1, "wait_B_ldx", 4'b0001, 1, 0, 3'd0);
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
    stepCycle();
    checkDut(1, "wait_B_ldy", 4'b0010, 1, 0, 3'd1);
    stepCycle();
    checkDut(1, "wait_B_alu", 4'b0011, 1, 0, 3'd2);
    stepCycle();
    checkDut(1, "wait_B_done", 4'b0000, 1, 1, 3'd2);
    stepCycle();
    checkDut(1, "wait_B_idle", 4'b0000, 0, 0, 3'd0);

    // Abort beats sw_valid while waiting on dutB.
    applyStimulus(1'b1, 2'b00, 1'b0, 1'b0);
    stepCycle();
    checkDut(1, "abortwait_B_wait", 4'b0000, 1, 0, 3'd0);
    applyStimulus(1'b0, 2'b00, 1'b1, 1'b1);
    stepCycle();
    checkDut(1, "abortwait_B_idle", 4'b0000, 0, 0, 3'd0);
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
    stepCycle();
    checkDut(1, "abortwait_B_nodone", 4'b0000, 0, 0, 3'd0);

    // op10 on dutC: each code held three cycles, mid-run start ignored.
    resetAll();
    applyStimulus(1'b1, 2'b10, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      stepCycle();
      checkDut(2, $sformatf("hold_C[%0d]", i), 4'(2 + i / 3), 1, 0, 3'(i / 3));
      if (i == 3) applyStimulus(1'b1, 2'b11, 1'b0, 1'b0);
      else        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
    end
    stepCycle();
    checkDut(2, "hold_C_done", 4'b0000, 1, 1, 3'd3);
    stepCycle();
    checkDut(2, "hold_C_idle", 4'b0000, 0, 0, 3'd0);

    // op11 on dutC with sw_valid held high throughout.
    resetAll();
    applyStimulus(1'b1, 2'b11, 1'b1, 1'b0);
    stepCycle();
    checkDut(2, "swheld_C_wait", 4'b0000, 1, 0, 3'd0);
    applyStimulus(1'b0, 2'b00, 1'b1, 1'b0);
    stepCycle();
    checkDut(2, "swheld_C_first", 4'b0001, 1, 0, 3'd0);
    cyc       = 2;
    doneCount = 0;
    while (busyC && cyc < 60) begin
      stepCycle();
      cyc++;
      if (doneC) doneCount++;
    end
    checkInt("swheld_C_length", cyc, 21);
    checkInt("swheld_C_donecount", doneCount, 1);
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);

    // Asynchronous reset in the middle of op11 step 3 on dutA.
    resetAll();
    applyStimulus(1'b1, 2'b11, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      stepCycle();
      checkDut(0, $sformatf("rstrun_A[%0d]", i), 4'(1 + i), 1, 0, 3'(i));
      applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
    end
    Resetn = 1'b0;
    #1;
    checkDut(0, "rstrun_A_async", 4'b0000, 0, 0, 3'd0);
    stepCycle();
    Resetn = 1'b1;
    doneCount = 0;
    for (int i = 0; i < 6; i++) begin
      stepCycle();
      if (doneA || busyA) doneCount++;
    end
    checkInt("rstrun_A_quiet", doneCount, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
